divider_hilo: RTL and testbench
===============================

Name: divider_hilo

Overview:
- Sequential unsigned divider with HI/LO result registers.
- Receives the 6-bit function code from the ALU control unit, which holds DIVU for 32 clocks and then issues the 6'b111111 HI/LO-open code.
- Executes one restoring-division iteration per clock and commits remainder to HI and quotient to LO only on the open code.
- Answers MFHI/MFLO reads on its data output.

Parameters:
WIDTH, 32, operand/result width; iteration count equals WIDTH
DIVU, 6'b011011, divide function code
MFHI, 6'b010000, read-HI function code
MFLO, 6'b010010, read-LO function code
OPEN_HILO, 6'b111111, commit-result code from ALU control

Ports:
clk  input  1  system clock, all state updates on posedge
reset  input  1  synchronous, active-high reset
dataA  input  WIDTH  dividend
dataB  input  WIDTH  divisor
Signal  input  6  function code from ALU control
dataOut  output  WIDTH  HI/LO read data
busy  output  1  division iterations in progress
done  output  1  result computed, awaiting OPEN_HILO

Behaviour:
- States: IDLE, RUN, DONE. Internal regs: rem (WIDTH+1 bits), quo (WIDTH), dvs (WIDTH), cnt (clog2(WIDTH)+1 bits), HI, LO.
- Reset (sampled at posedge): state=IDLE, rem/quo/dvs/cnt=0, HI=LO=0. busy=0, done=0, dataOut=0. Reset overrides all other inputs, including mid-run.
- Iteration step (restoring):
  - Form {rem[WIDTH-1:0], quo[WIDTH-1]}.
  - If it is >= dvs: subtract dvs and shift 1 into quo LSB; otherwise shift in 0.
  - cnt++.
- IDLE, Signal==DIVU at edge:
  - Latch dataB into dvs.
  - Perform iteration 1 on rem=0, quo=dataA in the same edge.
  - cnt=1. Go to RUN.
- RUN, Signal==DIVU: one iteration per edge. The edge that makes cnt==WIDTH goes to DONE. With WIDTH=32, DONE is entered on the 32nd consecutive DIVU edge.
- RUN, Signal==OPEN_HILO before cnt==WIDTH: abort to IDLE; HI/LO unchanged.
- RUN, any other code: abort to IDLE; HI/LO unchanged.
- DONE, Signal==OPEN_HILO: HI<=rem[WIDTH-1:0], LO<=quo; go to IDLE. This is the only path that writes HI/LO.
- DONE, Signal==DIVU: discard result and restart as from IDLE (new load plus iteration 1).
- DONE, any other code: hold result; stay in DONE.
- IDLE, OPEN_HILO: no effect.
- Operands are sampled only on the load edge. dataA/dataB changes during RUN have no effect.
- Divisor zero: no special case. The algorithm yields quo=all ones, rem=dividend (5/0 -> LO=0xFFFFFFFF, HI=5). No exception flag.
- busy=1 iff state==RUN. done=1 iff state==DONE. Both are decoded from registered state.
- dataOut (combinational from registers):
  - Signal==MFHI -> HI.
  - Signal==MFLO -> LO.
  - Otherwise 0.
  - A read on the same edge that HI/LO is written shows the old value until after the edge.
- Unsigned arithmetic only; no sign handling.
- Total latency: DIVU first seen -> HI/LO valid = 33 edges (32 iterations plus OPEN_HILO commit).

Test Plan:
- 100/7: DIVU held 32 clocks, then OPEN_HILO one clock, then MFHI/MFLO -> done high after edge 32; dataOut=2 on MFHI, 14 on MFLO.
- 0xFFFFFFFF/1 and 0x12345678/0x10000 -> (HI,LO) = (0, 0xFFFFFFFF) and (0x5678, 0x1234).
- 5/0 -> HI=5, LO=0xFFFFFFFF; no hang, busy drops after 32 edges.
- Abort: Signal changes DIVU -> ADD after 10 edges -> state IDLE, busy=0; previous HI/LO (from the 100/7 test) still read 2/14. A following OPEN_HILO changes nothing.
- Reset asserted at edge 15 of a run -> next cycle busy=0, done=0, HI=LO=0. A fresh 100/7 after release completes correctly.
- Operand hold: dataA/dataB toggled randomly during RUN -> result equals the operands present on the load edge. OPEN_HILO while IDLE -> HI/LO unchanged.

Source files
------------

// File: rtl/divider_hilo.sv
// rtl/divider_hilo.sv - sequential restoring unsigned divider with HI/LO result registers
module divider_hilo #(
  parameter int         WIDTH     = 32,
  parameter logic [5:0] DIVU      = 6'b011011,
  parameter logic [5:0] MFHI      = 6'b010000,
  parameter logic [5:0] MFLO      = 6'b010010,
  parameter logic [5:0] OPEN_HILO = 6'b111111
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [5:0]       Signal,
  output logic [WIDTH-1:0] dataOut,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  logic             load;
  logic             step;
  logic             commit;
  logic [WIDTH:0]   src_rem;
  logic [WIDTH-1:0] src_quo;
  logic [WIDTH-1:0] src_dvs;
  logic [CW-1:0]    src_cnt;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   rem_step;
  logic [WIDTH-1:0] quo_step;
  logic [CW-1:0]    cnt_step;

  // One restoring iteration; on a load edge it operates on the fresh operands
  always_comb begin
    src_rem = load ? '0 : rem;
    src_quo = load ? dataA : quo;
    src_dvs = load ? dataB : dvs;
    src_cnt = load ? '0 : cnt;
    trial   = {src_rem[WIDTH-1:0], src_quo[WIDTH-1]};
    if (trial >= {1'b0, src_dvs}) begin
      rem_step = trial - {1'b0, src_dvs};
      quo_step = {src_quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_step = trial;
      quo_step = {src_quo[WIDTH-2:0], 1'b0};
    end
    cnt_step = src_cnt + CW'(1);
  end

  // Next-state and control decode
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    step     = 1'b0;
    commit   = 1'b0;
    case (state)
      IDLE: begin
        if (Signal == DIVU) begin
          load     = 1'b1;
          step     = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (Signal == DIVU) begin
          step     = 1'b1;
          state_nx = (cnt_step == CW'(WIDTH)) ? DONE : RUN;
        end else begin
          state_nx = IDLE;
        end
      end
      DONE: begin
        if (Signal == OPEN_HILO) begin
          commit   = 1'b1;
          state_nx = IDLE;
        end else if (Signal == DIVU) begin
          load     = 1'b1;
          step     = 1'b1;
          state_nx = RUN;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Datapath registers: iteration state, operand latch and HI/LO commit
  always_ff @(posedge clk) begin
    if (reset) begin
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      cnt <= '0;
      hi  <= '0;
      lo  <= '0;
    end else begin
      if (step) begin
        rem <= rem_step;
        quo <= quo_step;
        dvs <= src_dvs;
        cnt <= cnt_step;
      end
      if (commit) begin
        hi <= rem[WIDTH-1:0];
        lo <= quo;
      end
    end
  end

  // Status flags decoded from registered state
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // HI/LO read port
  always_comb begin
    dataOut = '0;
    if (Signal == MFHI)      dataOut = hi;
    else if (Signal == MFLO) dataOut = lo;
  end

endmodule

// File: tb/tb_divider_hilo.sv
// tb/tb_divider_hilo.sv - directed self-checking bench for divider_hilo
module tb_divider_hilo;

  localparam logic [5:0] DIVU      = 6'b011011;
  localparam logic [5:0] MFHI      = 6'b010000;
  localparam logic [5:0] MFLO      = 6'b010010;
  localparam logic [5:0] OPEN_HILO = 6'b111111;
  localparam logic [5:0] ADD       = 6'b100000;
  localparam logic [5:0] NOP       = 6'b000000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [5:0]  Signal;
  logic [31:0] dataOut;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[7];

  divider_hilo dut (
    .clk     (clk),
    .reset   (reset),
    .dataA   (dataA),
    .dataB   (dataB),
    .Signal  (Signal),
    .dataOut (dataOut),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] ehi, input logic [31:0] elo);
    Signal = MFHI;
    #1 chk({tag, "_hi"}, dataOut, ehi);
    Signal = MFLO;
    #1 chk({tag, "_lo"}, dataOut, elo);
    Signal = NOP;
  endtask

  task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo,
                        input bit toggle, input int hold);
    @(negedge clk);
    Signal = DIVU;
    dataA  = a;
    dataB  = b;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      if (toggle) begin
        dataA = $urandom;
        dataB = $urandom;
      end
      if (i == 31) begin
        chk({tag, "_busy31"}, 32'(busy), 32'd1);
        chk({tag, "_done31"}, 32'(done), 32'd0);
      end
    end
    chk({tag, "_done32"}, 32'(done), 32'd1);
    chk({tag, "_busy32"}, 32'(busy), 32'd0);
    Signal = NOP;
    for (int i = 0; i < hold; i++) @(negedge clk);
    if (hold > 0) chk({tag, "_done_hold"}, 32'(done), 32'd1);
    Signal = OPEN_HILO;
    @(negedge clk);
    chk({tag, "_done_after_open"}, 32'(done), 32'd0);
    chk({tag, "_busy_after_open"}, 32'(busy), 32'd0);
    read_hilo(tag, ehi, elo);
  endtask

  initial begin
    vecs[0] = '{a: 32'd100,        b: 32'd7,        hi: 32'd2,      lo: 32'd14};
    vecs[1] = '{a: 32'hFFFFFFFF,   b: 32'd1,        hi: 32'd0,      lo: 32'hFFFFFFFF};
    vecs[2] = '{a: 32'h12345678,   b: 32'h00010000, hi: 32'h5678,   lo: 32'h1234};
    vecs[3] = '{a: 32'd5,          b: 32'd0,        hi: 32'd5,      lo: 32'hFFFFFFFF};
    vecs[4] = '{a: 32'd7,          b: 32'd100,      hi: 32'd7,      lo: 32'd0};
    vecs[5] = '{a: 32'hFFFFFFFF,   b: 32'hFFFFFFFF, hi: 32'd0,      lo: 32'd1};
    vecs[6] = '{a: 32'h80000000,   b: 32'd3,        hi: 32'd2,      lo: 32'h2AAAAAAA};

    reset  = 1'b1;
    Signal = NOP;
    dataA  = '0;
    dataB  = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    read_hilo("rst", 32'd0, 32'd0);
    chk("rst_nop_out", dataOut, 32'd0);
    reset = 1'b0;

    for (int v = 0; v < 7; v++)
      do_div($sformatf("vec%0d", v), vecs[v].a, vecs[v].b, vecs[v].hi, vecs[v].lo, 1'b0, 0);

    // Abort after 10 DIVU edges keeps previous HI/LO; a stray OPEN_HILO while idle does nothing
    do_div("pre_abort", 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 0);
    @(negedge clk);
    Signal = DIVU;
    dataA  = 32'd9;
    dataB  = 32'd2;
    repeat (10) @(negedge clk);
    chk("abort_busy_before", 32'(busy), 32'd1);
    Signal = ADD;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    read_hilo("abort", 32'd2, 32'd14);
    Signal = OPEN_HILO;
    @(negedge clk);
    chk("idle_open_busy", 32'(busy), 32'd0);
    read_hilo("idle_open", 32'd2, 32'd14);

    // Reset on the 15th edge of a run
    @(negedge clk);
    Signal = DIVU;
    dataA  = 32'd100;
    dataB  = 32'd7;
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    reset = 1'b0;
    read_hilo("midrst", 32'd0, 32'd0);
    do_div("post_rst", 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 0);

    // Operands toggled during RUN are ignored; result held in DONE across other codes
    do_div("hold", 32'd1000, 32'd9, 32'd1, 32'd111, 1'b1, 3);

    // DIVU in DONE discards the result and restarts on new operands
    @(negedge clk);
    Signal = DIVU;
    dataA  = 32'd50;
    dataB  = 32'd3;
    repeat (32) @(negedge clk);
    chk("restart_done_first", 32'(done), 32'd1);
    dataA = 32'd77;
    dataB = 32'd10;
    @(negedge clk);
    chk("restart_busy", 32'(busy), 32'd1);
    chk("restart_done", 32'(done), 32'd0);
    repeat (31) @(negedge clk);
    chk("restart_done_second", 32'(done), 32'd1);
    Signal = OPEN_HILO;
    @(negedge clk);
    read_hilo("restart", 32'd7, 32'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
